fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
//
// PURPOSE
// Instruction-fetch stage sitting directly upstream of the instruction memory.
// Owns the PC, drives the combinational IMem address, and captures the returned
// word into an IF/ID output register with a valid/ready handshake toward decode.
// Handles redirects (branch/jump), flush, halt and decode back-pressure.
//
// PARAMETERS
// RESET_PC    32'h0000_0000  PC value loaded on reset
// PC_STEP     4              byte increment per sequential fetch
//
// PORTS
// clk             in   1   single clock, all state updates on rising edge
// rst             in   1   synchronous, active-high reset
// imem_addr       out  32  byte address to IMem; equals pc (combinational)
// imem_instr      in   32  instruction word returned by IMem in the same cycle
// redirect_valid  in   1   redirect request from execute (branch taken / jump)
// redirect_target in   32  byte address of new fetch target
// halt_req        in   1   stop fetching (syscall/halt decoded downstream)
// id_ready        in   1   decode can accept the current id_* word
// id_valid        out  1   id_* holds a valid fetched instruction
// id_instr        out  32  fetched instruction
// id_pc           out  32  address the instruction was fetched from
// id_pc_plus4     out  32  id_pc + PC_STEP (link/branch base)
// misalign_err    out  1   one-cycle pulse: redirect target had [1:0] != 0
// halted          out  1   FSM is in S_HALT
// fetch_count     out  32  number of instructions accepted by decode
//
// BEHAVIOUR
// - Reset (rst=1 at edge): pc<=RESET_PC, state<=S_RUN, id_valid<=0,
//   id_instr/id_pc/id_pc_plus4<=0, misalign_err<=0, fetch_count<=0.
// - imem_addr = pc always (also during reset/halt); IMem read latency is 0.
// - FSM states: S_RUN (fetching), S_HALT (no new fetches).
//   S_RUN -> S_HALT when halt_req=1 and redirect_valid=0.
//   S_HALT -> S_RUN only on redirect_valid=1 (or rst). halt_req ignored in S_HALT.
// - Load condition: load = (state==S_RUN) & ~redirect_valid & ~halt_req
//   & (~id_valid | id_ready).
//   On load: id_instr<=imem_instr, id_pc<=pc, id_pc_plus4<=pc+PC_STEP,
//   id_valid<=1, pc<=pc+PC_STEP. Latency: word at pc is on id_* one cycle later.
// - Handshake: transfer when id_valid & id_ready; id_* must stay stable while
//   id_valid=1 & id_ready=0. Transfer without load: id_valid<=0.
//   Transfer and load in same cycle: back-to-back, id_valid stays 1.
// - Redirect (highest priority after rst): pc<={redirect_target[31:2],2'b00},
//   id_valid<=0 (flush, regardless of id_ready), state<=S_RUN.
//   misalign_err<=1 for exactly that cycle if redirect_target[1:0]!=0, else 0.
//   A transfer in the redirect cycle (id_valid&id_ready) still counts.
// - Halt: on entering S_HALT pc holds; an already-valid id_* word is retained
//   and may still drain via handshake; no further loads.
// - fetch_count increments by 1 on every handshake transfer; wraps 2^32-1 -> 0.
// - pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 -> 32'h0000_0000;
//   id_pc_plus4 wraps identically.
// - rst asserted mid-operation overrides redirect/halt/handshake that cycle.
//
// TESTING
// 1. Reset then id_ready=1, IMem words 0x11,0x22,0x33 at 0,4,8 -> id_valid
//    rises cycle 1; id_instr 0x11,0x22,0x33 with id_pc 0,4,8 on cycles 1-3.
// 2. Hold id_ready=0 for 3 cycles with id_valid=1 -> id_* stable, pc holds,
//    fetch_count unchanged; release -> next word follows next cycle, no loss.
// 3. Redirect to 0x40 while id_valid=1,id_ready=0 -> next cycle id_valid=0,
//    pc=0x40; following cycle id_pc=0x40. Target 0x43 -> pc=0x40, misalign_err
//    pulse of exactly 1 cycle.
// 4. halt_req at pc=0x10 -> halted=1, pc stays 0x10, pending word drains once,
//    no further id_valid; redirect to 0x0 -> halted=0, fetch resumes at 0x0.
// 5. Redirect to 0xFFFF_FFFC, id_ready=1 -> id_pc 0xFFFF_FFFC then 0x0,
//    id_pc_plus4 of first = 0x0.
// 6. rst asserted together with redirect_valid and halt_req -> pc=RESET_PC,
//    id_valid=0, halted=0, fetch_count=0 next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, drives a zero-latency
//               IMem address and captures the returned word into an IF/ID
//               register with a valid/ready handshake toward decode. Handles
//               redirects, halt and decode back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misalign_err,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        transfer;
  logic        load;

  // Sequential next PC; 32-bit modulo arithmetic wraps naturally.
  assign pc_next_seq = pc + STEP;

  // Decode consumes the held word this cycle.
  assign transfer = id_valid & id_ready;

  // A new word is captured only while running, with no redirect/halt pending,
  // and only if the output register is empty or being drained this cycle.
  assign load = (state == S_RUN) & ~redirect_valid & ~halt_req
                & (~id_valid | id_ready);

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  // PC, FSM, IF/ID register, misalign pulse and accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= S_RUN;
      id_valid     <= 1'b0;
      id_instr     <= 32'h0;
      id_pc        <= 32'h0;
      id_pc_plus4  <= 32'h0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0;
    end else begin
      misalign_err <= 1'b0;

      // A handshake in a redirect cycle still counts as delivered.
      if (transfer) begin
        fetch_count <= fetch_count + 32'h1;
      end

      if (redirect_valid) begin
        // Redirect flushes the IF/ID word regardless of id_ready and
        // forces a word-aligned target; low bits only raise the error pulse.
        pc           <= {redirect_target[31:2], 2'b00};
        id_valid     <= 1'b0;
        state        <= S_RUN;
        misalign_err <= |redirect_target[1:0];
      end else begin
        if ((state == S_RUN) && halt_req) begin
          state <= S_HALT;
        end

        if (load) begin
          id_instr    <= imem_instr;
          id_pc       <= pc;
          id_pc_plus4 <= pc_next_seq;
          id_valid    <= 1'b1;
          pc          <= pc_next_seq;
        end else if (transfer) begin
          id_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misalign_err;
  logic        halted;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: fixed words at 0/4/8, address-derived elsewhere.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign imem_instr = imem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .misalign_err(misalign_err), .halted(halted), .fetch_count(fetch_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    halt_req = 1'b0; id_ready = 1'b0;
    tick(); tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h want 0", id_valid); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 00000000", imem_addr); end
    vectors++; if (fetch_count !== 32'h0) begin miscompares++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %0h want 0", halted); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %0h want 0", misalign_err); end
    vectors++; if (id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      miscompares++; $display("FAIL reset_idregs got %h/%h/%h want 0/0/0", id_instr, id_pc, id_pc_plus4); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h11; exp_instr[1] = 32'h22; exp_instr[2] = 32'h33;
    rst = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (id_valid !== 1'b1 || id_instr !== exp_instr[i] || id_pc !== 32'(4*i)) begin
        miscompares++; $display("FAIL stream_%0d got v=%0h instr=%h pc=%h want v=1 instr=%h pc=%h",
                                i, id_valid, id_instr, id_pc, exp_instr[i], 32'(4*i)); end
      vectors++; if (id_pc_plus4 !== 32'(4*i+4)) begin
        miscompares++; $display("FAIL stream_plus4_%0d got %h want %h", i, id_pc_plus4, 32'(4*i+4)); end
    end
    vectors++; if (fetch_count !== 32'd2) begin miscompares++; $display("FAIL stream_count got %0d want 2", fetch_count); end
  endtask

  task automatic test_backpressure;
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (id_valid !== 1'b1 || id_instr !== 32'h33 || id_pc !== 32'h8 || imem_addr !== 32'hC || fetch_count !== 32'd2) begin
        miscompares++; $display("FAIL stall_%0d got v=%0h instr=%h idpc=%h pc=%h cnt=%0d want 1/00000033/00000008/0000000c/2",
                                i, id_valid, id_instr, id_pc, imem_addr, fetch_count); end
    end
    id_ready = 1'b1;
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== 32'hDEAD_000C || fetch_count !== 32'd3 || imem_addr !== 32'h10) begin
      miscompares++; $display("FAIL stall_release got v=%0h idpc=%h instr=%h cnt=%0d pc=%h want 1/0000000c/dead000c/3/00000010",
                              id_valid, id_pc, id_instr, fetch_count, imem_addr); end
  endtask

  task automatic test_redirect;
    id_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h40 || misalign_err !== 1'b0 || fetch_count !== 32'd3) begin
      miscompares++; $display("FAIL redir_flush got v=%0h pc=%h mis=%0h cnt=%0d want 0/00000040/0/3",
                              id_valid, imem_addr, misalign_err, fetch_count); end
    redirect_valid = 1'b0; id_ready = 1'b1;
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || imem_addr !== 32'h44) begin
      miscompares++; $display("FAIL redir_fetch got v=%0h idpc=%h pc=%h want 1/00000040/00000044", id_valid, id_pc, imem_addr); end
    redirect_valid = 1'b1; redirect_target = 32'h43;
    tick();
    vectors++; if (misalign_err !== 1'b1 || imem_addr !== 32'h40 || id_valid !== 1'b0 || fetch_count !== 32'd4) begin
      miscompares++; $display("FAIL misalign_pulse got mis=%0h pc=%h v=%0h cnt=%0d want 1/00000040/0/4",
                              misalign_err, imem_addr, id_valid, fetch_count); end
    redirect_valid = 1'b0;
    tick();
    vectors++; if (misalign_err !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h40) begin
      miscompares++; $display("FAIL misalign_clear got mis=%0h v=%0h idpc=%h want 0/1/00000040", misalign_err, id_valid, id_pc); end
  endtask

  task automatic test_halt;
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hC;
    tick();
    redirect_valid = 1'b0;
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'hC || imem_addr !== 32'h10) begin
      miscompares++; $display("FAIL halt_setup got v=%0h idpc=%h pc=%h want 1/0000000c/00000010", id_valid, id_pc, imem_addr); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    vectors++; if (halted !== 1'b1 || imem_addr !== 32'h10 || id_valid !== 1'b1 || id_pc !== 32'hC) begin
      miscompares++; $display("FAIL halt_enter got h=%0h pc=%h v=%0h idpc=%h want 1/00000010/1/0000000c",
                              halted, imem_addr, id_valid, id_pc); end
    tick();
    vectors++; if (halted !== 1'b1 || imem_addr !== 32'h10 || id_valid !== 1'b1) begin
      miscompares++; $display("FAIL halt_hold got h=%0h pc=%h v=%0h want 1/00000010/1", halted, imem_addr, id_valid); end
    id_ready = 1'b1;
    tick();
    vectors++; if (id_valid !== 1'b0 || fetch_count !== 32'd5) begin
      miscompares++; $display("FAIL halt_drain got v=%0h cnt=%0d want 0/5", id_valid, fetch_count); end
    tick();
    vectors++; if (id_valid !== 1'b0 || imem_addr !== 32'h10 || halted !== 1'b1 || fetch_count !== 32'd5) begin
      miscompares++; $display("FAIL halt_idle got v=%0h pc=%h h=%0h cnt=%0d want 0/00000010/1/5",
                              id_valid, imem_addr, halted, fetch_count); end
    redirect_valid = 1'b1; redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (halted !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      miscompares++; $display("FAIL halt_exit got h=%0h pc=%h v=%0h want 0/00000000/0", halted, imem_addr, id_valid); end
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h11 || imem_addr !== 32'h4) begin
      miscompares++; $display("FAIL halt_resume got v=%0h idpc=%h instr=%h pc=%h want 1/00000000/00000011/00000004",
                              id_valid, id_pc, id_instr, imem_addr); end
  endtask

  task automatic test_wrap;
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0 || fetch_count !== 32'd6) begin
      miscompares++; $display("FAIL wrap_redir got pc=%h v=%0h cnt=%0d want fffffffc/0/6", imem_addr, id_valid, fetch_count); end
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== 32'h2152_FFFC || imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL wrap_top got v=%0h idpc=%h p4=%h instr=%h pc=%h want 1/fffffffc/00000000/2152fffc/00000000",
                              id_valid, id_pc, id_pc_plus4, id_instr, imem_addr); end
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || id_instr !== 32'h11 || fetch_count !== 32'd7) begin
      miscompares++; $display("FAIL wrap_zero got v=%0h idpc=%h p4=%h instr=%h cnt=%0d want 1/00000000/00000004/00000011/7",
                              id_valid, id_pc, id_pc_plus4, id_instr, fetch_count); end
  endtask

  task automatic test_reset_priority;
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; halt_req = 1'b1; id_ready = 1'b1;
    tick();
    vectors++; if (imem_addr !== 32'h0 || id_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'd0 || misalign_err !== 1'b0) begin
      miscompares++; $display("FAIL rst_priority got pc=%h v=%0h h=%0h cnt=%0d mis=%0h want 00000000/0/0/0/0",
                              imem_addr, id_valid, halted, fetch_count, misalign_err); end
    rst = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; id_ready = 1'b0;
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_addr !== 32'h4) begin
      miscompares++; $display("FAIL rst_restart got v=%0h idpc=%h pc=%h want 1/00000000/00000004", id_valid, id_pc, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
